// File: rtl/dv_fifo_scoreboard.sv
// dv_fifo_scoreboard: cycle-accurate checker for a synchronous FIFO.
// It snoops the FIFO write/read ports and flags, mirrors them in a shadow FIFO,
// counts errors and transactions, and produces a sticky end-of-test verdict.
//
// Ports:
//   clk_i          - clock
//   rst_ni         - synchronous active-low reset
//   wr_en_i        - snooped write request
//   wr_data_i      - snooped write data
//   full_i         - snooped full flag
//   rd_en_i        - snooped read request
//   rd_data_i      - snooped read data, valid the cycle after an accepted read
//   empty_i        - snooped empty flag
//   test_end_i     - pulse: no further traffic will be issued
//   test_done_o    - sticky, verdict is final
//   test_passed_o  - verdict, meaningful while test_done_o is high
//   timeout_o      - sticky, idle watchdog expired
//   err_count_o    - saturating error count
//   txn_count_o    - saturating accepted read + write count
//
// Optional feature: define DV_SB_FLAG_CHECK_EN to compare full_i/empty_i
// against the shadow FIFO occupancy every active cycle.
module dv_fifo_scoreboard #(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  full_i,
    input  logic                  rd_en_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  empty_i,
    input  logic                  test_end_i,
    output logic                  test_done_o,
    output logic                  test_passed_o,
    output logic                  timeout_o,
    output logic [7:0]            err_count_o,
    output logic [15:0]           txn_count_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_exp;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_chk_pend;
    logic [WDW-1:0]        r_wd;

    logic        w_wr;
    logic        w_rd;
    logic        w_full_m;
    logic        w_empty_m;
    logic        w_ovf;
    logic        w_unf;
    logic        w_push;
    logic        w_pop;
    logic        w_mis;
    logic [1:0]  w_flag_err;
    logic [2:0]  w_err_inc;
    logic [8:0]  w_err_sum;
    logic [16:0] w_txn_sum;
    logic        w_idle;
    logic        w_wd_expire;

    assign w_wr      = wr_en_i && !full_i;
    assign w_rd      = rd_en_i && !empty_i;
    assign w_full_m  = r_count == (AW+1)'(DEPTH);
    assign w_empty_m = r_count == '0;
    // A write into a full model is legal when a read frees a slot in the same cycle.
    assign w_ovf     = w_wr && w_full_m && !w_rd;
    assign w_unf     = w_rd && w_empty_m;
    assign w_push    = w_wr && !w_ovf;
    assign w_pop     = w_rd && !w_unf;
    assign w_mis     = r_chk_pend && (rd_data_i != r_exp);

`ifdef DV_SB_FLAG_CHECK_EN
    assign w_flag_err = {1'b0, full_i != w_full_m} + {1'b0, empty_i != w_empty_m};
`else
    assign w_flag_err = 2'd0;
`endif

    assign w_err_inc   = {2'b0, w_mis} + {2'b0, w_ovf} + {2'b0, w_unf} + {1'b0, w_flag_err};
    assign w_err_sum   = {1'b0, err_count_o} + {6'b0, w_err_inc};
    assign w_txn_sum   = {1'b0, txn_count_o} + {16'b0, w_wr} + {16'b0, w_rd};
    assign w_idle      = !w_wr && !w_rd;
    assign w_wd_expire = w_idle && (r_wd == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= RUN;
            r_exp         <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_chk_pend    <= 1'b0;
            r_wd          <= '0;
            test_done_o   <= 1'b0;
            test_passed_o <= 1'b0;
            timeout_o     <= 1'b0;
            err_count_o   <= '0;
            txn_count_o   <= '0;
        end else if (r_state == DONE) begin
            // Everything else is frozen; the verdict is published one cycle after entry.
            test_done_o   <= 1'b1;
            test_passed_o <= (err_count_o == '0) && !timeout_o && (txn_count_o != '0);
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_data_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_exp    <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_chk_pend  <= w_pop;
            r_count     <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            err_count_o <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            txn_count_o <= w_txn_sum[16] ? 16'hFFFF : w_txn_sum[15:0];
            r_wd        <= w_idle ? r_wd + 1'b1 : '0;
            if (w_wd_expire) begin
                timeout_o <= 1'b1;
                r_state   <= DONE;
            end else if (r_state == RUN && test_end_i) begin
                r_state <= DRAIN;
            end else if (r_state == DRAIN && w_empty_m && !r_chk_pend) begin
                r_state <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_dv_fifo_scoreboard.sv
// tb_dv_fifo_scoreboard: plays the snooped FIFO, models the scoreboard with queues
// and compares every output each cycle, plus literal checks for the test plan.
module tb_dv_fifo_scoreboard;
    localparam int DW      = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 10000;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          wr_en_i;
    logic [DW-1:0] wr_data_i;
    logic          full_i;
    logic          rd_en_i;
    logic [DW-1:0] rd_data_i;
    logic          empty_i;
    logic          test_end_i;
    logic          test_done_o;
    logic          test_passed_o;
    logic          timeout_o;
    logic [7:0]    err_count_o;
    logic [15:0]   txn_count_o;

    dv_fifo_scoreboard #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .full_i(full_i), .rd_en_i(rd_en_i), .rd_data_i(rd_data_i), .empty_i(empty_i),
        .test_end_i(test_end_i), .test_done_o(test_done_o), .test_passed_o(test_passed_o),
        .timeout_o(timeout_o), .err_count_o(err_count_o), .txn_count_o(txn_count_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural scoreboard model: a queue plus plain counters.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_exp;
    bit            m_pend, m_to, m_done, m_pass;
    int            m_err, m_txn, m_state, m_idle, m_pushes, m_pops;
    int            sz0, e;
    bit            pend0, aw_m, ar_m, ovf, unf;

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            mq.delete();
            m_pend = 0; m_exp = '0; m_err = 0; m_txn = 0; m_to = 0; m_state = 0;
            m_idle = 0; m_done = 0; m_pass = 0; m_pushes = 0; m_pops = 0;
        end else if (m_state == 2) begin
            m_done = 1;
            m_pass = (m_err == 0) && !m_to && (m_txn != 0);
        end else begin
            sz0   = mq.size();
            pend0 = m_pend;
            aw_m  = wr_en_i && !full_i;
            ar_m  = rd_en_i && !empty_i;
            ovf   = aw_m && sz0 == DEPTH && !ar_m;
            unf   = ar_m && sz0 == 0;
            e     = int'(m_pend && rd_data_i != m_exp) + int'(ovf) + int'(unf);
`ifdef DV_SB_FLAG_CHECK_EN
            e += int'(full_i != (sz0 == DEPTH)) + int'(empty_i != (sz0 == 0));
`endif
            m_pend = 0;
            if (ar_m && !unf) begin
                m_exp = mq.pop_front();
                m_pend = 1;
                m_pops++;
            end
            if (aw_m && !ovf) begin
                mq.push_back(wr_data_i);
                m_pushes++;
            end
            m_err = (m_err + e > 255) ? 255 : m_err + e;
            m_txn = (m_txn + int'(aw_m) + int'(ar_m) > 65535) ? 65535 : m_txn + int'(aw_m) + int'(ar_m);
            m_idle = (aw_m || ar_m) ? 0 : m_idle + 1;
            if (m_idle == TIMEOUT) begin
                m_to = 1;
                m_state = 2;
            end else if (m_state == 0 && test_end_i) begin
                m_state = 1;
            end else if (m_state == 1 && sz0 == 0 && !pend0) begin
                m_state = 2;
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_on) begin
            chk("done", test_done_o, m_done);
            chk("passed", test_passed_o, m_pass);
            chk("timeout", timeout_o, m_to);
            chk("err_count", err_count_o, m_err);
            chk("txn_count", txn_count_o, m_txn);
            chk("model_count", dut.r_count, mq.size());
        end
    end

    // Stand-in for the snooped FIFO: produces honest flags and read data.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] f_rd = '0;
    bit corrupt_next = 0, lie_empty = 0, end_now = 0, rnd_corrupt = 0;
    int rd_idx = 0, bad_rd = 0;

    task automatic cyc(input bit we, input logic [DW-1:0] wd, input bit re);
        bit aw, ar;
        wr_en_i    = we;
        wr_data_i  = wd;
        rd_en_i    = re;
        full_i     = (fq.size() == DEPTH);
        empty_i    = lie_empty ? 1'b0 : (fq.size() == 0);
        rd_data_i  = corrupt_next ? 8'h7F : f_rd;
        corrupt_next = 0;
        test_end_i = end_now;
        end_now    = 0;
        aw = we && !full_i;
        ar = re && !empty_i;
        if (ar) begin
            rd_idx++;
            f_rd = fq.pop_front();
            corrupt_next = (rd_idx == bad_rd) || (rnd_corrupt && $urandom_range(0, 19) == 0);
        end
        if (aw) fq.push_back(wd);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        cyc(0, '0, 0);
        rst_ni = 1'b1;
        fq.delete();
        rd_idx = 0;
        bad_rd = 0;
        corrupt_next = 0;
    endtask

    task automatic finish_test();
        cyc(0, '0, 0);
        end_now = 1;
        cyc(0, '0, 0);
        for (int i = 0; i < 20 && !test_done_o; i++) cyc(0, '0, 0);
        chk("done_within_bound", test_done_o, 1);
    endtask

    initial begin
        rst_ni = 1'b0; wr_en_i = 0; wr_data_i = '0; full_i = 0; rd_en_i = 0;
        rd_data_i = '0; empty_i = 1; test_end_i = 0;
        do_reset();
        chk_on = 1'b1;
        chk("rst_done", test_done_o, 0);
        chk("rst_err", err_count_o, 0);
        chk("rst_txn", txn_count_o, 0);

        // Fill to full, one refused write, drain, end.
        for (int i = 1; i <= 16; i++) cyc(1, 8'(i), 0);
        chk("t1_count16", dut.r_count, 16);
        cyc(1, 8'hAA, 0);
        for (int i = 0; i < 16; i++) cyc(0, '0, 1);
        finish_test();
        chk("t1_err", err_count_o, 0);
        chk("t1_txn", txn_count_o, 32);
        chk("t1_passed", test_passed_o, 1);

        // Third read word corrupted.
        do_reset();
        bad_rd = 3;
        for (int i = 1; i <= 16; i++) cyc(1, 8'(i), 0);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, '0, 1);
            if (i == 3) chk("t2_err_before", err_count_o, 0);
            if (i == 4) chk("t2_err_after", err_count_o, 1);
        end
        finish_test();
        chk("t2_err_final", err_count_o, 1);
        chk("t2_passed", test_passed_o, 0);

        // Simultaneous read/write at count 8 and at full.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 8'(i), 0);
        for (int i = 0; i < 20; i++) cyc(1, 8'(8 + i), 1);
        chk("t3_count8", dut.r_count, 8);
        for (int i = 0; i < 8; i++) cyc(1, 8'(40 + i), 0);
        chk("t3_count16", dut.r_count, 16);
        for (int i = 0; i < 20; i++) cyc(1, 8'(60 + i), 1);
        chk("t3_count15", dut.r_count, 15);
        chk("t3_wr_ptr", dut.r_wr_ptr, 7);
        chk("t3_rd_ptr", dut.r_rd_ptr, 8);
        chk("t3_err", err_count_o, 0);
        for (int i = 0; i < 15; i++) cyc(0, '0, 1);
        finish_test();
        chk("t3_passed", test_passed_o, 1);

        // Idle watchdog.
        do_reset();
        for (int i = 0; i < TIMEOUT + 50 && !timeout_o; i++) cyc(0, '0, 0);
        chk("t4_timeout", timeout_o, 1);
        cyc(0, '0, 0);
        chk("t4_done", test_done_o, 1);
        chk("t4_passed", test_passed_o, 0);

        // Lying empty flag at count 0.
        do_reset();
        lie_empty = 1;
        for (int i = 0; i < 3; i++) cyc(0, '0, 0);
        lie_empty = 0;
        cyc(0, '0, 0);
`ifdef DV_SB_FLAG_CHECK_EN
        chk("t5_flag_err", err_count_o, 3);
`else
        chk("t5_flag_err", err_count_o, 0);
`endif

        // Reset while draining with five entries.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 8'(i), 0);
        end_now = 1;
        cyc(0, '0, 0);
        cyc(0, '0, 0);
        cyc(0, '0, 0);
        chk("t6_drain_hold", test_done_o, 0);
        do_reset();
        chk("t6_rst_txn", txn_count_o, 0);
        chk("t6_rst_count", dut.r_count, 0);
        end_now = 1;
        cyc(0, '0, 0);
        cyc(0, '0, 0);
        chk("t6_not_done_yet", test_done_o, 0);
        cyc(0, '0, 0);
        chk("t6_done_2cyc", test_done_o, 1);
        chk("t6_no_txn_fail", test_passed_o, 0);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 8'(i + 9), 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1);
        finish_test();
        chk("t6_clean_pass", test_passed_o, 1);

        // Random traffic with occasional corruption and early test_end.
        rnd_corrupt = 1;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 400; i++) begin
                if (i == 250 + r * 30) end_now = 1;
                cyc(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) != 0);
            end
            for (int i = 0; i < DEPTH + 2; i++) cyc(0, '0, 1);
            finish_test();
        end
        rnd_corrupt = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
